qspi_arbiter: RTL and testbench

//  Shares a single QSPI engine request/response port between two requesters
//  (e.g. the AXI register interface and a boot-time flash loader). Accepts one

---
 rtl/qspi_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_qspi_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_arbiter.sv
// Two-requester front end for a single QSPI engine: one transaction in flight,
// round-robin on ties, start strobe to the engine, and a watchdog while waiting.
module qspi_arbiter #(
  parameter int unsigned      CMD_W       = 8,
  parameter int unsigned      BANKMAP_W   = 8,
  parameter int unsigned      ADDR_W      = 32,
  parameter int unsigned      ERR_W       = 8,
  parameter int unsigned      TIMEOUT     = 32'd1000000,
  parameter logic [ERR_W-1:0] TIMEOUT_ERR = {ERR_W{1'b1}}
) (
  input  logic                 clk,
  input  logic                 resetn,

  input  logic                 r0_valid,
  output logic                 r0_ready,
  input  logic [CMD_W-1:0]     r0_cmd,
  input  logic [BANKMAP_W-1:0] r0_bankmap,
  input  logic [ADDR_W-1:0]    r0_addr,
  input  logic [63:0]          r0_wdata,
  output logic                 r0_done,
  output logic [63:0]          r0_rdata,
  output logic [ERR_W-1:0]     r0_error,

  input  logic                 r1_valid,
  output logic                 r1_ready,
  input  logic [CMD_W-1:0]     r1_cmd,
  input  logic [BANKMAP_W-1:0] r1_bankmap,
  input  logic [ADDR_W-1:0]    r1_addr,
  input  logic [63:0]          r1_wdata,
  output logic                 r1_done,
  output logic [63:0]          r1_rdata,
  output logic [ERR_W-1:0]     r1_error,

  output logic [CMD_W-1:0]     qspi_cmd,
  output logic [BANKMAP_W-1:0] qspi_bankmap,
  output logic [ADDR_W-1:0]    qspi_addr,
  output logic [63:0]          qspi_wdata,
  output logic                 qspi_start,
  input  logic                 qspi_idle,
  input  logic [63:0]          qspi_rdata,
  input  logic [ERR_W-1:0]     qspi_error,

  output logic                 busy,
  output logic                 owner
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  localparam bit          TMO_EN   = (TIMEOUT != 0);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT) - 32'd1;

  state_e                 state_q;
  logic                   last_q;
  logic                   owner_q;
  logic                   busy_q;
  logic [31:0]            wd_cnt_q;
  logic [CMD_W-1:0]       cmd_q;
  logic [BANKMAP_W-1:0]   bankmap_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [63:0]            wdata_q;
  logic                   start_q;
  logic                   r0_ready_q;
  logic                   r1_ready_q;
  logic                   r0_done_q;
  logic                   r1_done_q;
  logic [63:0]            r0_rdata_q;
  logic [63:0]            r1_rdata_q;
  logic [ERR_W-1:0]       r0_error_q;
  logic [ERR_W-1:0]       r1_error_q;

  logic                   grant_s;
  logic                   pick_s;
  logic [CMD_W-1:0]       sel_cmd_s;
  logic [BANKMAP_W-1:0]   sel_bankmap_s;
  logic [ADDR_W-1:0]      sel_addr_s;
  logic [63:0]            sel_wdata_s;
  logic                   fin_s;
  logic [63:0]            fin_rdata_s;
  logic [ERR_W-1:0]       fin_err_s;

  // On a tie the requester that did not win last time gets the grant.
  function automatic logic arb_pick(input logic v0, input logic v1, input logic last);
    if (v0 && v1) begin
      return ~last;
    end else begin
      return v1;
    end
  endfunction

  // Grant decision: only from IDLE and only while the engine reports idle.
  always_comb begin
    grant_s = 1'b0;
    pick_s  = 1'b0;
    if ((state_q == ST_IDLE) && qspi_idle && (r0_valid || r1_valid)) begin
      grant_s = 1'b1;
      pick_s  = arb_pick(r0_valid, r1_valid, last_q);
    end else begin
      grant_s = 1'b0;
      pick_s  = 1'b0;
    end
  end

  // Request fields of the requester being granted.
  always_comb begin
    if (pick_s) begin
      sel_cmd_s     = r1_cmd;
      sel_bankmap_s = r1_bankmap;
      sel_addr_s    = r1_addr;
      sel_wdata_s   = r1_wdata;
    end else begin
      sel_cmd_s     = r0_cmd;
      sel_bankmap_s = r0_bankmap;
      sel_addr_s    = r0_addr;
      sel_wdata_s   = r0_wdata;
    end
  end

  // Completion in WAIT; an engine result beats a simultaneous watchdog expiry.
  always_comb begin
    fin_s       = 1'b0;
    fin_rdata_s = 64'd0;
    fin_err_s   = {ERR_W{1'b0}};
    if (state_q == ST_WAIT) begin
      if (qspi_idle) begin
        fin_s       = 1'b1;
        fin_rdata_s = qspi_rdata;
        fin_err_s   = qspi_error;
      end else if (TMO_EN && (wd_cnt_q == TMO_LAST)) begin
        fin_s       = 1'b1;
        fin_rdata_s = 64'd0;
        fin_err_s   = TIMEOUT_ERR;
      end else begin
        fin_s       = 1'b0;
        fin_rdata_s = 64'd0;
        fin_err_s   = {ERR_W{1'b0}};
      end
    end else begin
      fin_s       = 1'b0;
      fin_rdata_s = 64'd0;
      fin_err_s   = {ERR_W{1'b0}};
    end
  end

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      busy_q     <= 1'b0;
      wd_cnt_q   <= 32'd0;
      cmd_q      <= {CMD_W{1'b0}};
      bankmap_q  <= {BANKMAP_W{1'b0}};
      addr_q     <= {ADDR_W{1'b0}};
      wdata_q    <= 64'd0;
      start_q    <= 1'b0;
      r0_ready_q <= 1'b0;
      r1_ready_q <= 1'b0;
      r0_done_q  <= 1'b0;
      r1_done_q  <= 1'b0;
      r0_rdata_q <= 64'd0;
      r1_rdata_q <= 64'd0;
      r0_error_q <= {ERR_W{1'b0}};
      r1_error_q <= {ERR_W{1'b0}};
    end else begin
      r0_ready_q <= 1'b0;
      r1_ready_q <= 1'b0;
      start_q    <= 1'b0;
      r0_done_q  <= 1'b0;
      r1_done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_s) begin
            cmd_q      <= sel_cmd_s;
            bankmap_q  <= sel_bankmap_s;
            addr_q     <= sel_addr_s;
            wdata_q    <= sel_wdata_s;
            r0_ready_q <= ~pick_s;
            r1_ready_q <= pick_s;
            owner_q    <= pick_s;
            last_q     <= pick_s;
            wd_cnt_q   <= 32'd0;
            busy_q     <= 1'b1;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          start_q <= 1'b1;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (fin_s) begin
            // Only the owner's result registers move; the other side keeps its last result.
            if (owner_q) begin
              r1_done_q  <= 1'b1;
              r1_rdata_q <= fin_rdata_s;
              r1_error_q <= fin_err_s;
            end else begin
              r0_done_q  <= 1'b1;
              r0_rdata_q <= fin_rdata_s;
              r0_error_q <= fin_err_s;
            end
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            wd_cnt_q <= wd_cnt_q + 32'd1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign r0_ready     = r0_ready_q;
  assign r1_ready     = r1_ready_q;
  assign r0_done      = r0_done_q;
  assign r1_done      = r1_done_q;
  assign r0_rdata     = r0_rdata_q;
  assign r1_rdata     = r1_rdata_q;
  assign r0_error     = r0_error_q;
  assign r1_error     = r1_error_q;
  assign qspi_cmd     = cmd_q;
  assign qspi_bankmap = bankmap_q;
  assign qspi_addr    = addr_q;
  assign qspi_wdata   = wdata_q;
  assign qspi_start   = start_q;
  assign busy         = busy_q;
  assign owner        = owner_q;

endmodule

// File: tb/tb_qspi_arbiter.sv
// Bench for qspi_arbiter: directed scenarios plus randomized traffic, all checked
// every cycle against a transaction-level model of the arbiter.
module tb_qspi_arbiter;
  localparam int TMO = 16;

  logic clk, resetn;
  logic [1:0]       rv;
  logic [1:0][7:0]  rcmd, rbm;
  logic [1:0][31:0] raddr;
  logic [1:0][63:0] rwd;
  logic        qspi_idle;
  logic [63:0] qspi_rdata;
  logic [7:0]  qspi_error;

  logic        r0_ready, r1_ready, r0_done, r1_done, qspi_start, busy, owner;
  logic [63:0] r0_rdata, r1_rdata, qspi_wdata;
  logic [7:0]  r0_error, r1_error, qspi_cmd, qspi_bankmap;
  logic [31:0] qspi_addr;
  logic [1:0]  dut_rdy;
  assign dut_rdy = {r1_ready, r0_ready};

  qspi_arbiter #(.CMD_W(8), .BANKMAP_W(8), .ADDR_W(32), .ERR_W(8), .TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .r0_valid(rv[0]), .r0_ready(r0_ready), .r0_cmd(rcmd[0]), .r0_bankmap(rbm[0]),
    .r0_addr(raddr[0]), .r0_wdata(rwd[0]), .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_error(r0_error),
    .r1_valid(rv[1]), .r1_ready(r1_ready), .r1_cmd(rcmd[1]), .r1_bankmap(rbm[1]),
    .r1_addr(raddr[1]), .r1_wdata(rwd[1]), .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_error(r1_error),
    .qspi_cmd(qspi_cmd), .qspi_bankmap(qspi_bankmap), .qspi_addr(qspi_addr), .qspi_wdata(qspi_wdata),
    .qspi_start(qspi_start), .qspi_idle(qspi_idle), .qspi_rdata(qspi_rdata), .qspi_error(qspi_error),
    .busy(busy), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  // Reference model: one transaction in flight, m_age = cycles since its grant.
  bit m_active, m_last;
  int m_age;
  logic [1:0] e_ready, e_done;
  logic e_start, e_busy, e_owner;
  logic [1:0][63:0] e_rdata;
  logic [1:0][7:0]  e_err;
  logic [7:0] e_cmd, e_bm;
  logic [31:0] e_addr;
  logic [63:0] e_wd;
  // Stimulus knobs and observations.
  bit rand_mode = 0, keep_req = 0, eng_fixed = 0, force_busy = 0;
  int eng_left = 0, dir_plan = 0, start_cyc = 0;
  int rdy_cyc[2], done_cyc[2], cnt_rdy[2], cnt_done[2];
  int glog[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic m_reset();
    m_active = 0; m_last = 1; m_age = 0;
    e_ready = 2'b00; e_done = 2'b00; e_start = 0; e_busy = 0; e_owner = 0;
    e_rdata = '0; e_err = '0; e_cmd = 8'h00; e_bm = 8'h00; e_addr = 32'h0; e_wd = 64'h0;
  endtask

  task automatic m_finish(input logic [63:0] d, input logic [7:0] e);
    e_rdata[e_owner] = d; e_err[e_owner] = e; e_done[e_owner] = 1'b1;
    m_active = 0; e_busy = 0;
  endtask

  task automatic m_step();
    int n;
    if (!resetn) begin
      m_reset();
    end else begin
      e_ready = 2'b00; e_done = 2'b00; e_start = 0;
      if (!m_active) begin
        if (qspi_idle && (rv != 2'b00)) begin
          n = (rv == 2'b11) ? int'(!m_last) : int'(rv[1]);
          e_cmd = rcmd[n]; e_bm = rbm[n]; e_addr = raddr[n]; e_wd = rwd[n];
          e_ready[n] = 1'b1; m_last = (n == 1); e_owner = (n == 1);
          m_active = 1; m_age = 1; e_busy = 1;
        end
      end else if (m_age == 1) begin
        e_start = 1; m_age = 2;
      end else if (qspi_idle) begin
        m_finish(qspi_rdata, qspi_error);
      end else if (TMO != 0 && (m_age - 2) == TMO - 1) begin
        m_finish(64'h0, 8'hFF);
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic new_fields(input int n);
    rcmd[n] = 8'($urandom()); rbm[n] = 8'($urandom());
    raddr[n] = $urandom(); rwd[n] = {$urandom(), $urandom()};
  endtask

  task automatic tick();
    for (int n = 0; n < 2; n++) begin
      if (rv[n] && dut_rdy[n]) begin
        if (keep_req) new_fields(n); else rv[n] = 1'b0;
      end else if (rand_mode) begin
        if (!rv[n]) begin
          if ($urandom_range(0, 5) == 0) begin rv[n] = 1'b1; new_fields(n); end
        end else if ($urandom_range(0, 19) == 0) begin
          rv[n] = 1'b0;
        end
      end
    end
    if (!eng_fixed) begin
      qspi_rdata = {$urandom(), $urandom()};
      qspi_error = ($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'h00;
    end
    if (e_start) begin
      qspi_idle = 1'b0;
      if (rand_mode) eng_left = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 6)) : int'($urandom_range(10, 22));
      else eng_left = dir_plan;
    end else if (force_busy) begin
      qspi_idle = 1'b0;
    end else if (eng_left > 0) begin
      qspi_idle = 1'b0; eng_left--;
    end else if (rand_mode && !m_active && $urandom_range(0, 11) == 0) begin
      qspi_idle = 1'b0; eng_left = int'($urandom_range(0, 3));
    end else begin
      qspi_idle = 1'b1;
    end
    @(posedge clk);
    m_step();
    @(negedge clk);
    cyc++;
    chk("handshake", 128'({r0_ready, r1_ready, qspi_start, busy, owner, r0_done, r1_done}),
        128'({e_ready[0], e_ready[1], e_start, e_busy, e_owner, e_done[0], e_done[1]}));
    chk("r0_result", 128'({r0_rdata, r0_error}), 128'({e_rdata[0], e_err[0]}));
    chk("r1_result", 128'({r1_rdata, r1_error}), 128'({e_rdata[1], e_err[1]}));
    chk("eng_fields", 128'({qspi_cmd, qspi_bankmap, qspi_addr, qspi_wdata}), 128'({e_cmd, e_bm, e_addr, e_wd}));
    if (r0_ready) begin rdy_cyc[0] = cyc; cnt_rdy[0]++; glog.push_back(0); end
    if (r1_ready) begin rdy_cyc[1] = cyc; cnt_rdy[1]++; glog.push_back(1); end
    if (qspi_start) start_cyc = cyc;
    if (r0_done) begin done_cyc[0] = cyc; cnt_done[0]++; end
    if (r1_done) begin done_cyc[1] = cyc; cnt_done[1]++; end
  endtask

  function automatic bit evt(input int which);
    case (which)
      0: return r0_ready;
      1: return r1_ready;
      2: return r0_done;
      3: return r1_done;
      4: return qspi_start;
      default: return !busy;
    endcase
  endfunction

  task automatic wait_evt(input int which, input int bound, input string nm);
    bit hit = 0;
    for (int i = 0; i < bound && !hit; i++) begin
      tick();
      hit = evt(which);
    end
    checks++;
    if (!hit) begin
      failures++;
      $display("FAIL %s: got no event within %0d cycles, want one", nm, bound);
    end
  endtask

  initial begin
    resetn = 1'b0; rv = 2'b00; rcmd = '0; rbm = '0; raddr = '0; rwd = '0;
    qspi_idle = 1'b1; qspi_rdata = 64'h0; qspi_error = 8'h00;
    m_reset();
    repeat (3) tick();
    chk("rst_ctrl", 128'({busy, owner, qspi_start, r0_ready, r1_ready, r0_done, r1_done}), 128'(0));
    chk("rst_data", 128'({r0_rdata, r1_error, qspi_addr}), 128'(0));
    chk("rst_model_last", 128'(m_last), 128'(1));
    resetn = 1'b1;
    tick();

    // 1: single r0 transaction, engine busy for 10 cycles.
    eng_fixed = 1; qspi_rdata = 64'h1122334455667788; qspi_error = 8'h00; dir_plan = 9;
    rv[0] = 1'b1; rcmd[0] = 8'h0B; raddr[0] = 32'h0000_1000; rbm[0] = 8'h01; rwd[0] = 64'h0;
    wait_evt(2, 40, "t1_done");
    chk("t1_rdy_to_start", 128'(start_cyc - rdy_cyc[0]), 128'(1));
    chk("t1_start_to_done", 128'(done_cyc[0] - start_cyc), 128'(11));
    chk("t1_rdata", 128'(r0_rdata), 128'(64'h1122334455667788));
    chk("t1_error", 128'(r0_error), 128'(0));
    chk("t1_cmd_addr", 128'({qspi_cmd, qspi_addr}), 128'({8'h0B, 32'h0000_1000}));
    chk("t1_model_rdata", 128'(e_rdata[0]), 128'(64'h1122334455667788));

    // 2: both requesting continuously from reset -> grants alternate starting with r0.
    resetn = 1'b0; tick(); tick(); resetn = 1'b1;
    dir_plan = 0; glog.delete(); keep_req = 1; rv = 2'b11; new_fields(0); new_fields(1);
    for (int i = 0; i < 80 && glog.size() < 4; i++) tick();
    keep_req = 0; rv = 2'b00;
    chk("t2_grant_count", 128'(glog.size()), 128'(4));
    for (int k = 0; k < 4; k++)
      if (k < glog.size()) chk($sformatf("t2_grant%0d", k), 128'(glog[k]), 128'(k % 2));
    wait_evt(5, 40, "t2_drain");

    // 3: engine stuck -> watchdog at start+16; pending r1 waits for engine idle.
    dir_plan = 40; rv[0] = 1'b1; new_fields(0);
    wait_evt(0, 10, "t3_r0_ready");
    rv[1] = 1'b1; new_fields(1);
    wait_evt(2, 40, "t3_r0_done");
    dir_plan = 2;
    chk("t3_start_to_done", 128'(done_cyc[0] - start_cyc), 128'(16));
    chk("t3_result", 128'({r0_rdata, r0_error}), 128'({64'h0, 8'hFF}));
    chk("t3_model_err", 128'(e_err[0]), 128'(8'hFF));
    cnt_rdy[1] = 0;
    repeat (10) tick();
    chk("t3_no_grant_while_busy", 128'(cnt_rdy[1]), 128'(0));
    wait_evt(1, 40, "t3_r1_ready");
    wait_evt(3, 20, "t3_r1_done");

    // 4: engine idle exactly when the watchdog would fire -> engine result wins.
    qspi_rdata = 64'h0123456789ABCDEF; qspi_error = 8'h5A; dir_plan = 14;
    rv[0] = 1'b1; new_fields(0);
    wait_evt(2, 40, "t4_done");
    chk("t4_start_to_done", 128'(done_cyc[0] - start_cyc), 128'(16));
    chk("t4_result", 128'({r0_rdata, r0_error}), 128'({64'h0123456789ABCDEF, 8'h5A}));

    // 5: reset mid-WAIT, engine still busy afterwards.
    dir_plan = 30; rv[0] = 1'b1; new_fields(0);
    wait_evt(4, 20, "t5_start");
    repeat (5) tick();
    cnt_done[0] = 0; force_busy = 1; resetn = 1'b0;
    tick(); tick();
    chk("t5_rst_ctrl", 128'({busy, owner, qspi_start, r0_done}), 128'(0));
    chk("t5_rst_data", 128'({r0_rdata, r0_error, qspi_addr}), 128'(0));
    resetn = 1'b1; rv[0] = 1'b1; new_fields(0); cnt_rdy[0] = 0;
    repeat (8) tick();
    chk("t5_no_grant", 128'({cnt_rdy[0], cnt_done[0]}), 128'(0));
    force_busy = 0; eng_left = 0; dir_plan = 3;
    wait_evt(0, 10, "t5_ready");
    wait_evt(2, 20, "t5_done");

    // 6: r1 withdraws before it could be granted.
    dir_plan = 12; rv[0] = 1'b1; new_fields(0);
    wait_evt(0, 10, "t6_r0_ready");
    cnt_rdy[1] = 0; rv[1] = 1'b1; new_fields(1);
    repeat (3) tick();
    rv[1] = 1'b0;
    wait_evt(2, 30, "t6_r0_done");
    repeat (5) tick();
    chk("t6_no_r1_grant", 128'(cnt_rdy[1]), 128'(0));

    // Randomized traffic, timeouts and spontaneous engine activity.
    eng_fixed = 0; rand_mode = 1;
    repeat (3000) tick();
    rand_mode = 0; rv = 2'b00;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
